coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the candy vending Moore FSM. Converts raw mechanical coin-sensor lines (5-unit and 10-unit chutes) into clean, single-cycle coin codes on the 4-bit `coin` bus that the FSM samples each clock.
- Synchronises and debounces both sensors and rejects invalid insertions (both sensors active, or insertion while disabled) via a return pulse.
- Detects jammed sensors.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable-high cycles required before a coin is accepted. Legal range >= 1.
- JAM_CYCLES, 64: cycles a sensor may stay high after accept/reject before jam is declared. Must be > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sense_5  in  1  raw 5-unit chute sensor; asynchronous; high = coin present.
- sense_10  in  1  raw 10-unit chute sensor; asynchronous; high = coin present.
- accept_en  in  1  synchronous; high = downstream FSM is ready to take coins.
- coin  out  4  coin code to the vending FSM: 4'b0000 none, 4'b0101 five, 4'b1010 ten.
- coin_return  out  1  one-cycle pulse that opens the return flap.
- jam  out  1  high while in JAM state.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, debounce/jam counters=0, synchroniser flops=0.
  - coin=4'b0000, coin_return=0, jam=0, busy=0.
  - Reset mid-operation discards any pending coin; nothing is emitted after release.
- Synchronisation: each sensor passes through a 2-flop synchroniser. The FSM sees only the synchronised versions, s5 and s10.
- Outputs: all outputs are decoded from the registered state (Moore). There is no combinational path from any input to any output.
- States and transitions:
  - IDLE:
    - exactly one of s5/s10 high and accept_en=1 -> DEBOUNCE; latch coin type; cnt=0.
    - exactly one high and accept_en=0 -> REJECT.
    - both high -> REJECT.
    - otherwise stay in IDLE.
  - DEBOUNCE:
    - latched sensor high and other sensor low: if cnt==DEBOUNCE_CYCLES-1 -> EMIT, else cnt++.
    - latched sensor drops -> IDLE (glitch); no output, no return.
    - other sensor rises -> REJECT (overrides everything else).
    - accept_en is ignored once in DEBOUNCE.
  - EMIT: coin = latched code (0101 or 1010) for exactly one cycle -> RELEASE; cnt=0.
  - REJECT: coin_return=1 for exactly one cycle -> RELEASE; cnt=0.
  - RELEASE:
    - s5=0 and s10=0 -> IDLE.
    - otherwise cnt++; when cnt==JAM_CYCLES-1 -> JAM.
    - No new coin is accepted in this state.
  - JAM: jam=1; both sensors low -> IDLE; jam drops the cycle IDLE is entered.
- Latency: raw sensor first sampled high at edge k -> coin valid for the single cycle after edge k+2+DEBOUNCE_CYCLES. With the default of 4, that is the cycle after edge k+6.
- Output codes: coin is never a value other than 0000/0101/1010. coin and coin_return are never high in the same cycle.
- Counter width: $clog2(JAM_CYCLES) bits, shared between the debounce and jam counts. The counter saturates and never wraps.
- Simultaneous events:
  - both sensors rising on the same synchronised edge -> REJECT.
  - a coin held continuously yields exactly one coin pulse.
  - back-to-back coins require both sensors to pass through low (RELEASE -> IDLE) between them.

Decomposition:
- Shared package/include coin_defs holds:
  - COIN_NONE=4'b0000, COIN_5=4'b0101, COIN_10=4'b1010 (the vending FSM also uses these).
  - the state encoding localparams for IDLE, DEBOUNCE, EMIT, REJECT, RELEASE, JAM.
- One sub-module, sync_2ff (1-bit two-flop synchroniser with async active-low reset), instantiated once per sensor.

Test Plan:
- 5-unit coin: accept_en=1, sense_5 high for 20 cycles then low -> exactly one cycle of coin=0101 at edge k+7; coin_return=0; busy back to 0 after release.
- 10-unit then 5-unit: sense_10 pulse of 10 cycles, 5 cycles gap, sense_5 pulse of 10 cycles -> coin=1010 once, then coin=0101 once, in that order.
- Glitch: sense_5 high for 3 cycles (DEBOUNCE_CYCLES=4) -> coin stays 0000, coin_return=0, state returns to IDLE.
- Invalid: sense_5 and sense_10 rise together, or sense_5 with accept_en=0 -> one coin_return pulse, coin=0000 throughout.
- Jam: sense_10 held high for 100 cycles -> one coin=1010 pulse; jam=1 from 64 cycles after EMIT until sense_10 falls; jam=0 once back in IDLE.
- Reset mid-debounce: rst=0 for 2 cycles while in DEBOUNCE, sensor released before rst returns high -> all outputs 0 immediately, no coin emitted afterwards.

Source files
------------

// File: rtl/coin_defs.sv
// Shared coin codes and acceptor state encoding, also used by the vending FSM.
package coin_defs;

    localparam logic [3:0] COIN_NONE = 4'b0000;
    localparam logic [3:0] COIN_5    = 4'b0101;
    localparam logic [3:0] COIN_10   = 4'b1010;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEBOUNCE = 3'd1;
    localparam logic [2:0] S_EMIT     = 3'd2;
    localparam logic [2:0] S_REJECT   = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;
    localparam logic [2:0] S_JAM      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_DEBOUNCE = S_DEBOUNCE,
        ST_EMIT     = S_EMIT,
        ST_REJECT   = S_REJECT,
        ST_RELEASE  = S_RELEASE,
        ST_JAM      = S_JAM
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for an asynchronous sensor line.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw line through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the 5/10 chute sensors and emits single-cycle
// coin codes, return pulses and a jam flag, all from registers.
module coin_acceptor
    import coin_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_5,
    input  logic       sense_10,
    input  logic       accept_en,
    output logic [3:0] coin,
    output logic       coin_return,
    output logic       jam,
    output logic       busy
);
    localparam int CW = $clog2(JAM_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic s5, s10;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic sel10_q, sel10_d;
    logic lat_s, oth_s;
    logic [3:0] coin_q, coin_d;
    logic ret_q, ret_d, jam_q, jam_d, busy_q, busy_d;

    sync_2ff u_sync_5  (.clk(clk), .rst_n(rst), .d(sense_5),  .q(s5));
    sync_2ff u_sync_10 (.clk(clk), .rst_n(rst), .d(sense_10), .q(s10));

    // Next-state, shared counter and latched coin type.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel10_d = sel10_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        lat_s   = sel10_q ? s10 : s5;
        oth_s   = sel10_q ? s5 : s10;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s5 && s10) begin
                    state_d = ST_REJECT;
                end else if (s5 || s10) begin
                    if (accept_en) begin
                        state_d = ST_DEBOUNCE;
                        sel10_d = s10;
                    end else begin
                        state_d = ST_REJECT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                // A second coin appearing overrides a glitch or a completed count.
                if (oth_s) begin
                    state_d = ST_REJECT;
                end else if (!lat_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_EMIT, ST_REJECT: begin
                state_d = ST_RELEASE;
                cnt_d   = '0;
            end
            ST_RELEASE: begin
                if (!s5 && !s10) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == JAM_LAST) begin
                        state_d = ST_JAM;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_JAM: begin
                if (!s5 && !s10) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_JAM;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers decoded from the next state so they align with the state.
    always_comb begin
        coin_d = (state_d == ST_EMIT) ? (sel10_d ? COIN_10 : COIN_5) : COIN_NONE;
        ret_d  = (state_d == ST_REJECT);
        jam_d  = (state_d == ST_JAM);
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel10_q <= 1'b0;
            coin_q  <= COIN_NONE;
            ret_q   <= 1'b0;
            jam_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel10_q <= sel10_d;
            coin_q  <= coin_d;
            ret_q   <= ret_d;
            jam_q   <= jam_d;
            busy_q  <= busy_d;
        end
    end

    assign coin        = coin_q;
    assign coin_return = ret_q;
    assign jam         = jam_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised and directed bench for coin_acceptor, checked every cycle against an
// insertion-level reference model plus literal timing expectations.
module tb_coin_acceptor;
    localparam int DEB  = 4;
    localparam int JAMC = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sense_5 = 1'b0, sense_10 = 1'b0, accept_en = 1'b0;
    logic [3:0] coin;
    logic coin_return, jam, busy;

    int n_checks = 0, n_pass = 0, cyc = 0;

    coin_acceptor dut (
        .clk(clk), .rst(rst), .sense_5(sense_5), .sense_10(sense_10),
        .accept_en(accept_en), .coin(coin), .coin_return(coin_return),
        .jam(jam), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference model: tracks one insertion at a time in terms of how long the
    // synchronised sensors have been seen, not in terms of the RTL's states.
    bit m5a, m5b, m10a, m10b, s5m, s10m, lat, oth;
    int want, stable, wait_cnt;
    bit pulse, waiting, jammed;
    int e_coin;
    bit e_ret, e_jam, e_busy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m5a = 0; m5b = 0; m10a = 0; m10b = 0;
            want = 0; stable = 0; wait_cnt = 0;
            pulse = 0; waiting = 0; jammed = 0;
            e_coin = 0; e_ret = 0; e_jam = 0; e_busy = 0;
        end else begin
            s5m = m5b; s10m = m10b;
            m5b = m5a; m10b = m10a;
            m5a = sense_5; m10a = sense_10;
            e_coin = 0; e_ret = 0;
            if (pulse) begin
                pulse = 0; waiting = 1; wait_cnt = 0;
            end else if (waiting) begin
                if (!s5m && !s10m) begin
                    waiting = 0; jammed = 0;
                end else if (!jammed) begin
                    wait_cnt++;
                    if (wait_cnt == JAMC - 1) jammed = 1;
                end
            end else if (want != 0) begin
                lat = (want == 5) ? s5m : s10m;
                oth = (want == 5) ? s10m : s5m;
                if (oth) begin
                    want = 0; e_ret = 1; pulse = 1;
                end else if (!lat) begin
                    want = 0;
                end else begin
                    stable++;
                    if (stable == DEB) begin
                        e_coin = (want == 5) ? 5 : 10;
                        want = 0; pulse = 1;
                    end
                end
            end else if (s5m && s10m) begin
                e_ret = 1; pulse = 1;
            end else if (s5m || s10m) begin
                if (accept_en) begin
                    want = s5m ? 5 : 10; stable = 0;
                end else begin
                    e_ret = 1; pulse = 1;
                end
            end
            e_busy = pulse || waiting || (want != 0);
            e_jam = jammed;
        end
    end

    // Event log used by the directed checks.
    int n5, n10, nret, c5_first, c10_first, jam_rise;
    int coin_log[$];
    bit jam_prev = 0;

    // Single compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        check("coin", int'(coin), e_coin);
        check("coin_return", int'(coin_return), int'(e_ret));
        check("jam", int'(jam), int'(e_jam));
        check("busy", int'(busy), int'(e_busy));
        if (coin == 4'b0101) begin
            n5++; coin_log.push_back(5);
            if (c5_first < 0) c5_first = cyc;
        end
        if (coin == 4'b1010) begin
            n10++; coin_log.push_back(10);
            if (c10_first < 0) c10_first = cyc;
        end
        if (coin_return) nret++;
        if (jam && !jam_prev && jam_rise < 0) jam_rise = cyc;
        jam_prev = jam;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        n5 = 0; n10 = 0; nret = 0; c5_first = -1; c10_first = -1; jam_rise = -1;
        coin_log.delete();
    endtask

    int c0, kind, dur, gap;

    initial begin
        clear_log();
        #2;
        check("rst_coin", int'(coin), 0);
        check("rst_ret", int'(coin_return), 0);
        check("rst_jam", int'(jam), 0);
        check("rst_busy", int'(busy), 0);
        idle(3);
        rst = 1'b1;
        accept_en = 1'b1;
        idle(3);

        // 5-unit coin held 20 cycles
        clear_log();
        c0 = cyc; sense_5 = 1'b1;
        idle(20); sense_5 = 1'b0; idle(12);
        check("t1_n5", n5, 1);
        check("t1_latency", c5_first - c0, 7);
        check("t1_ret", nret, 0);
        check("t1_busy", int'(busy), 0);

        // 10 then 5
        clear_log();
        sense_10 = 1'b1; idle(10); sense_10 = 1'b0; idle(5);
        sense_5 = 1'b1; idle(10); sense_5 = 1'b0; idle(12);
        check("t2_count", coin_log.size(), 2);
        if (coin_log.size() == 2) begin
            check("t2_first", coin_log[0], 10);
            check("t2_second", coin_log[1], 5);
        end

        // glitch shorter than the debounce window
        clear_log();
        sense_5 = 1'b1; idle(3); sense_5 = 1'b0; idle(10);
        check("t3_coins", n5 + n10, 0);
        check("t3_ret", nret, 0);
        check("t3_busy", int'(busy), 0);

        // both sensors together
        clear_log();
        sense_5 = 1'b1; sense_10 = 1'b1; idle(6);
        sense_5 = 1'b0; sense_10 = 1'b0; idle(10);
        check("t4_ret", nret, 1);
        check("t4_coins", n5 + n10, 0);

        // insertion while disabled
        clear_log();
        accept_en = 1'b0; sense_5 = 1'b1; idle(6);
        sense_5 = 1'b0; idle(10); accept_en = 1'b1;
        check("t5_ret", nret, 1);
        check("t5_coins", n5 + n10, 0);

        // jam: 10-unit held for 100 cycles
        clear_log();
        sense_10 = 1'b1; idle(100);
        check("t6_jam_high", int'(jam), 1);
        sense_10 = 1'b0; idle(6);
        check("t6_n10", n10, 1);
        check("t6_jam_delay", jam_rise - c10_first, 64);
        check("t6_jam_low", int'(jam), 0);
        check("t6_busy", int'(busy), 0);

        // reset while debouncing
        clear_log();
        sense_5 = 1'b1; idle(4);
        check("t7_busy_pre", int'(busy), 1);
        rst = 1'b0; #1;
        check("t7_coin_rst", int'(coin), 0);
        check("t7_busy_rst", int'(busy), 0);
        idle(1); sense_5 = 1'b0; idle(1);
        rst = 1'b1; idle(15);
        check("t7_coins", n5 + n10, 0);
        check("t7_ret", nret, 0);

        // randomised insertions
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            dur = $urandom_range(1, 12);
            gap = $urandom_range(0, 8);
            accept_en = ($urandom_range(0, 7) != 0);
            if (kind == 0) dur = $urandom_range(60, 75);
            if (kind <= 7) begin
                if ($urandom_range(0, 1) == 1) sense_5 = 1'b1;
                else sense_10 = 1'b1;
            end else begin
                sense_5 = 1'b1; sense_10 = 1'b1;
            end
            for (int j = 0; j < dur; j++) begin
                @(negedge clk);
                if (kind == 7 && j == dur / 2) begin
                    sense_5 = 1'b1; sense_10 = 1'b1;
                end
            end
            sense_5 = 1'b0; sense_10 = 1'b0;
            idle(gap);
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
